// File: rtl/sys_arr_pkg.sv
// Shared timing constants and controller state type for the systolic array
// sequencer and its step timer.
package sys_arr_pkg;

    localparam int unsigned MUL_LEN = 3;
    localparam int unsigned ADD_LEN = 2;
    localparam int unsigned STEP    = MUL_LEN + ADD_LEN;
    localparam int unsigned DW      = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_W  = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/sysarr_step_timer.sv
// Per-step cycle counter broadcast to the MAC cells as mac_count; flags the
// last cycle of a step and parks there while the controller holds the step.
module sysarr_step_timer #(
    parameter  int unsigned STEP_LEN = 5,
    localparam int unsigned MW       = (STEP_LEN > 1) ? $clog2(STEP_LEN) : 1
) (
    input  logic          clk,
    input  logic          nRST,
    input  logic          en,
    input  logic          hold,
    output logic [MW-1:0] mac_count,
    output logic          end_c
);

    localparam logic [MW-1:0] LAST = MW'(STEP_LEN - 1);

    logic [MW-1:0] cnt_q;
    logic [MW-1:0] cnt_d;

    // Count up within a step, wrap on release, and read 0 whenever disabled.
    always_comb begin
        cnt_d = '0;
        if (en) begin
            if (cnt_q != LAST) begin
                cnt_d = cnt_q + MW'(1);
            end else if (hold) begin
                cnt_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mac_count = cnt_q;
    assign end_c     = en && (cnt_q == LAST);

endmodule

// File: rtl/sysarr_mac_ctrl.sv
// Sequencer for an N x N weight-stationary systolic array: loads weight rows,
// then steps the array over skewed input rows plus drain steps.
module sysarr_mac_ctrl
    import sys_arr_pkg::*;
#(
    parameter  int unsigned N        = 4,
    parameter  int unsigned ROWS_MAX = 64,
    localparam int unsigned NRW      = $clog2(ROWS_MAX + 1),
    localparam int unsigned WRW      = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned MW       = (STEP > 1) ? $clog2(STEP) : 1,
    localparam int unsigned SW       = $clog2(ROWS_MAX + 2 * N)
) (
    input  logic           clk,
    input  logic           nRST,
    input  logic           start,
    input  logic [NRW-1:0] num_rows,
    input  logic           reuse_weights,
    output logic           busy,
    output logic           done,
    input  logic           weight_valid,
    output logic           weight_ready,
    output logic [WRW-1:0] weight_row,
    input  logic           input_valid,
    output logic           input_ready,
    output logic           feed_zero,
    output logic           MAC_shift,
    output logic [MW-1:0]  mac_count,
    output logic           psum_valid,
    output logic [SW-1:0]  psum_step,
    input  logic           out_ready
);

    ctrl_state_t    state_q, state_d;
    logic [WRW-1:0] wr_q, wr_d;
    logic [SW-1:0]  step_q, step_d;
    logic [NRW-1:0] rows_q, rows_d;

    logic          end_c;
    logic          timer_en_c;
    logic          hold_c;
    logic          feed_c;
    logic          out_step_c;
    logic          last_step_c;
    logic          advance_c;
    logic [SW-1:0] total_c;

    // Step classification: feed steps carry input rows, output steps
    // produce bottom-row partial sums; the two overlap in the middle.
    assign total_c     = SW'(rows_q) + SW'(2 * N - 2);
    assign feed_c      = step_q < SW'(rows_q);
    assign out_step_c  = step_q >= SW'(N - 1);
    assign last_step_c = step_q == (total_c - SW'(1));
    assign advance_c   = (!feed_c || input_valid) && (!out_step_c || out_ready);
    assign timer_en_c  = state_q == COMPUTE;
    assign hold_c      = !advance_c;

    sysarr_step_timer #(
        .STEP_LEN (STEP)
    ) u_step_timer (
        .clk       (clk),
        .nRST      (nRST),
        .en        (timer_en_c),
        .hold      (hold_c),
        .mac_count (mac_count),
        .end_c     (end_c)
    );

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        step_d       = step_q;
        rows_d       = rows_q;
        busy         = 1'b0;
        done         = 1'b0;
        weight_ready = 1'b0;
        weight_row   = '0;
        input_ready  = 1'b0;
        feed_zero    = 1'b0;
        MAC_shift    = 1'b0;
        psum_valid   = 1'b0;
        psum_step    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rows_d = num_rows;
                    wr_d   = '0;
                    step_d = '0;
                    if (num_rows == '0) begin
                        state_d = DONE;
                    end else if (reuse_weights) begin
                        state_d = COMPUTE;
                    end else begin
                        state_d = LOAD_W;
                    end
                end
            end

            LOAD_W: begin
                busy         = 1'b1;
                weight_ready = 1'b1;
                weight_row   = wr_q;
                if (weight_valid) begin
                    if (wr_q == WRW'(N - 1)) begin
                        wr_d    = '0;
                        state_d = COMPUTE;
                    end else begin
                        wr_d = wr_q + WRW'(1);
                    end
                end
            end

            COMPUTE: begin
                busy      = 1'b1;
                feed_zero = !feed_c;
                // Handshakes are only offered in the step's end cycle and
                // stay up while either side stalls the step.
                if (end_c) begin
                    input_ready = feed_c;
                    psum_valid  = out_step_c;
                    if (out_step_c) begin
                        psum_step = step_q - SW'(N - 1);
                    end
                    if (advance_c) begin
                        MAC_shift = 1'b1;
                        if (last_step_c) begin
                            step_d  = '0;
                            state_d = DONE;
                        end else begin
                            step_d = step_q + SW'(1);
                        end
                    end
                end
            end

            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            wr_q    <= '0;
            step_q  <= '0;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            step_q  <= step_d;
            rows_q  <= rows_d;
        end
    end

endmodule

// File: tb/tb_sysarr_mac_ctrl.sv
// Self-checking bench for sysarr_mac_ctrl: per-cycle reference model plus
// per-job transaction totals, under directed and randomized handshakes.
module tb_sysarr_mac_ctrl;
    import sys_arr_pkg::*;

    localparam int N        = 4;
    localparam int ROWS_MAX = 64;
    localparam int ST       = int'(STEP);
    localparam int NRW      = $clog2(ROWS_MAX + 1);
    localparam int WRW      = $clog2(N);
    localparam int MW       = $clog2(ST);
    localparam int SW       = $clog2(ROWS_MAX + 2 * N);
    localparam int OW       = 7 + WRW + MW + SW;
    localparam int PH_IDLE  = 0;
    localparam int PH_LOAD  = 1;
    localparam int PH_COMP  = 2;
    localparam int PH_DONE  = 3;
    localparam int JOB_MAX_CYC = 3000;

    logic           clk = 1'b0;
    logic           nRST;
    logic           start;
    logic [NRW-1:0] num_rows;
    logic           reuse_weights;
    logic           busy;
    logic           done;
    logic           weight_valid;
    logic           weight_ready;
    logic [WRW-1:0] weight_row;
    logic           input_valid;
    logic           input_ready;
    logic           feed_zero;
    logic           MAC_shift;
    logic [MW-1:0]  mac_count;
    logic           psum_valid;
    logic [SW-1:0]  psum_step;
    logic           out_ready;
    logic [OW-1:0]  obs;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: job phase, latched rows, weights written, step index
    // and cycle-within-step.
    int m_ph, m_rows, m_wr, m_s, m_k;

    int job_rows;
    bit job_go;
    bit job_reuse;
    int cur_mode;
    int in_stall;
    int out_stall;

    always #5 clk = ~clk;

    sysarr_mac_ctrl #(
        .N        (N),
        .ROWS_MAX (ROWS_MAX)
    ) dut (
        .clk           (clk),
        .nRST          (nRST),
        .start         (start),
        .num_rows      (num_rows),
        .reuse_weights (reuse_weights),
        .busy          (busy),
        .done          (done),
        .weight_valid  (weight_valid),
        .weight_ready  (weight_ready),
        .weight_row    (weight_row),
        .input_valid   (input_valid),
        .input_ready   (input_ready),
        .feed_zero     (feed_zero),
        .MAC_shift     (MAC_shift),
        .mac_count     (mac_count),
        .psum_valid    (psum_valid),
        .psum_step     (psum_step),
        .out_ready     (out_ready)
    );

    assign obs = {busy, done, weight_ready, weight_row, input_ready, feed_zero,
                  MAC_shift, mac_count, psum_valid, psum_step};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph   = PH_IDLE;
        m_rows = 0;
        m_wr   = 0;
        m_s    = 0;
        m_k    = 0;
    endtask

    function automatic logic [OW-1:0] model_outs();
        bit comp = (m_ph == PH_COMP);
        bit endc = comp && (m_k == ST - 1);
        bit feed = m_s < m_rows;
        bit outs = m_s >= N - 1;
        bit adv  = (!feed || input_valid) && (!outs || out_ready);
        logic [WRW-1:0] wrow = (m_ph == PH_LOAD) ? WRW'(m_wr) : '0;
        logic [MW-1:0]  mc   = comp ? MW'(m_k) : '0;
        logic [SW-1:0]  ps   = (endc && outs) ? SW'(m_s - (N - 1)) : '0;
        return {m_ph != PH_IDLE, m_ph == PH_DONE, m_ph == PH_LOAD, wrow,
                endc && feed, comp && !feed, endc && adv, mc, endc && outs, ps};
    endfunction

    task automatic model_step();
        bit feed = m_s < m_rows;
        bit outs = m_s >= N - 1;
        bit adv  = (!feed || input_valid) && (!outs || out_ready);
        case (m_ph)
            PH_IDLE: if (start) begin
                m_rows = int'(num_rows);
                m_wr   = 0;
                m_s    = 0;
                m_k    = 0;
                m_ph   = (num_rows == 0) ? PH_DONE : (reuse_weights ? PH_COMP : PH_LOAD);
            end
            PH_LOAD: if (weight_valid) begin
                if (m_wr == N - 1) m_ph = PH_COMP;
                else m_wr++;
            end
            PH_COMP: begin
                if (m_k < ST - 1) begin
                    m_k++;
                end else if (adv) begin
                    m_k = 0;
                    if (m_s == m_rows + 2 * N - 3) m_ph = PH_DONE;
                    else m_s++;
                end
            end
            default: m_ph = PH_IDLE;
        endcase
    endtask

    // Mode 0: all handshakes high; 1: random; 2: input stall at step 1;
    // 3: output stall at step 3. start/num_rows are noise outside IDLE.
    task automatic drive_inputs();
        bit endc = (m_ph == PH_COMP) && (m_k == ST - 1);
        if (m_ph == PH_IDLE) begin
            start         = job_go;
            num_rows      = NRW'(job_rows);
            reuse_weights = job_reuse;
        end else begin
            start         = 1'($urandom_range(0, 1));
            num_rows      = NRW'($urandom_range(0, ROWS_MAX));
            reuse_weights = 1'($urandom_range(0, 1));
        end
        weight_valid = 1'b1;
        input_valid  = 1'b1;
        out_ready    = 1'b1;
        case (cur_mode)
            1: begin
                weight_valid = ($urandom_range(0, 3) != 0);
                input_valid  = ($urandom_range(0, 3) != 0);
                out_ready    = ($urandom_range(0, 4) != 0);
            end
            2: if (endc && m_s == 1 && in_stall > 0) begin
                input_valid = 1'b0;
                in_stall--;
            end
            3: if (endc && m_s == 3 && out_stall > 0) begin
                out_ready = 1'b0;
                out_stall--;
            end
            default: ;
        endcase
    endtask

    // Runs one job from IDLE back to IDLE; abort_s >= 0 resets mid-compute.
    task automatic run_job(input int rows, input bit reuse, input int mode, input int abort_s);
        int busy_n = 0, shifts = 0, psums = 0, wrs = 0, ins = 0, dones = 0, cyc = 0;
        int total = (rows == 0) ? 0 : rows + 2 * N - 2;
        int extra = (mode == 2) ? 3 : ((mode == 3) ? 2 : 0);
        bit aborted = 1'b0;
        bit left_idle = 1'b0;
        bit finished = 1'b0;
        job_rows  = rows;
        job_reuse = reuse;
        cur_mode  = mode;
        in_stall  = 3;
        out_stall = 2;
        job_go    = 1'b1;
        while (!finished && !aborted && cyc < JOB_MAX_CYC) begin
            drive_inputs();
            if (abort_s >= 0 && m_ph == PH_COMP && m_s == abort_s) begin
                #2 nRST = 1'b0;
                start = 1'b0;
                #1 check("rst_outs", obs, '0);
                model_reset();
                aborted = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_hold", obs, '0);
                    if (done) dones++;
                end
                #2 nRST = 1'b1;
                @(posedge clk);
                #1;
            end else begin
                @(negedge clk);
                check("outs", obs, model_outs());
                if (busy) busy_n++;
                if (done) dones++;
                if (MAC_shift) shifts++;
                if (weight_valid && weight_ready) begin
                    check("w_row", weight_row, wrs);
                    wrs++;
                end
                if (psum_valid && MAC_shift) begin
                    check("psum_step", psum_step, psums);
                    psums++;
                end
                if (input_valid && input_ready && MAC_shift) ins++;
                @(posedge clk);
                model_step();
                job_go = 1'b0;
                if (m_ph != PH_IDLE) left_idle = 1'b1;
                finished = left_idle && (m_ph == PH_IDLE);
                cyc++;
                #1;
            end
        end
        job_go = 1'b0;
        if (aborted) begin
            check("abort_done", dones, 0);
        end else begin
            check("job_end", finished, 1);
            check("shifts", shifts, total);
            check("psums", psums, (rows == 0) ? 0 : rows + N - 1);
            check("w_xfers", wrs, (reuse || rows == 0) ? 0 : N);
            check("in_xfers", ins, rows);
            check("done_cnt", dones, 1);
            if (mode != 1) begin
                check("busy_len", busy_n,
                      (rows == 0) ? 1 : ((reuse ? 0 : N) + total * ST + 1 + extra));
            end
        end
    endtask

    initial begin
        nRST          = 1'b0;
        start         = 1'b0;
        num_rows      = '0;
        reuse_weights = 1'b0;
        weight_valid  = 1'b0;
        input_valid   = 1'b0;
        out_ready     = 1'b0;
        job_go        = 1'b0;
        job_reuse     = 1'b0;
        job_rows      = 0;
        cur_mode      = 0;
        in_stall      = 0;
        out_stall     = 0;
        model_reset();

        repeat (2) @(negedge clk);
        check("reset_outs", obs, '0);
        nRST = 1'b1;
        @(posedge clk);
        #1;

        run_job(3, 1'b0, 0, -1);
        run_job(1, 1'b1, 0, -1);
        run_job(3, 1'b0, 2, -1);
        run_job(3, 1'b1, 3, -1);
        run_job(0, 1'b0, 0, -1);
        run_job(0, 1'b1, 0, -1);
        run_job(6, 1'b0, 0, 4);
        run_job(3, 1'b0, 0, -1);
        run_job(ROWS_MAX, 1'b1, 0, -1);
        run_job(ROWS_MAX, 1'b0, 1, -1);
        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), 1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sysarr_mac_ctrl.md
Name: sysarr_mac_ctrl

Overview:
- Sequencer for the N x N weight-stationary systolic array of MAC cells.
- Loads N weight rows, then drives the shared MAC_shift and count signals to every MAC cell, one step at a time.
- Streams a skewed set of input rows and flags when bottom-row partial sums are valid for the output deskew buffer.
- Sits between the tensor-core issue logic (start/done), the input and weight buffers (valid/ready) and the array.

Parameters:
- N, 4, array dimension (rows = columns).
- ROWS_MAX, 64, maximum input rows per job.
- MUL_LEN, package constant, multiplier latency in cycles.
- ADD_LEN, package constant, adder latency in cycles.
- STEP = MUL_LEN+ADD_LEN, derived, cycles per array step.

Ports:
- clk  in  1  clock
- nRST  in  1  asynchronous active-low reset
- start  in  1  job request, sampled only in IDLE
- num_rows  in  clog2(ROWS_MAX+1)  input rows for this job, latched on start
- reuse_weights  in  1  skip weight load, latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- weight_valid  in  1  weight buffer has a row
- weight_ready  out  1  controller accepts a weight row
- weight_row  out  clog2(N)  row index being written
- input_valid  in  1  input buffer has a row
- input_ready  out  1  controller consumes an input row
- feed_zero  out  1  feeder must drive 0 into the array (drain steps)
- MAC_shift  out  1  broadcast to all MAC cells
- mac_count  out  clog2(STEP)  broadcast count to all MAC cells
- psum_valid  out  1  bottom-row out_accumulate valid this cycle
- psum_step  out  clog2(ROWS_MAX+2N)  output step index
- out_ready  in  1  deskew buffer can accept

Behaviour:
- Reset is asynchronous and applies mid-job. All outputs and counters go to 0 and the state goes to IDLE; the partial job is abandoned and no done pulse is produced.
- IDLE:
  - start=1 and num_rows=0: go to DONE.
  - Otherwise, reuse_weights=1: go to COMPUTE.
  - Otherwise: go to LOAD_W.
  - start is ignored outside IDLE.
- LOAD_W:
  - weight_ready=1, weight_row=wr (wr starts at 0).
  - Each cycle with weight_valid&&weight_ready increments wr.
  - Transfer with wr=N-1 moves to COMPUTE next cycle, with mac_count=0 and step=0.
  - weight_valid low stalls with no timeout.
- COMPUTE:
  - mac_count increments each cycle from 0 to STEP-1.
  - The step ends at mac_count=STEP-1 ("end cycle").
  - TOTAL = num_rows+2N-2 steps, indexed s=0..TOTAL-1.
  - Feed steps (s<num_rows): feed_zero=0 and input_ready=1 in the end cycle only.
  - Drain steps (s>=num_rows): feed_zero=1 and input_ready=0.
  - Output steps are N-1 <= s <= TOTAL-1. In the end cycle psum_valid=1 and psum_step=s-(N-1).
  - Step advance requires (feed step implies input_valid) AND (output step implies out_ready). When advance=1 in the end cycle: MAC_shift=1, mac_count wraps to 0, s increments.
  - When advance=0: mac_count holds at STEP-1, MAC_shift=0, and psum_valid/input_ready stay asserted. An input transfer is counted only when advance=1.
  - Both stall conditions at once: hold until both clear.
  - End cycle of s=TOTAL-1 with advance=1: go to DONE.
- DONE: done=1 for one cycle, then IDLE. start in the DONE cycle is ignored.
- MAC_shift is never asserted outside COMPUTE end cycles. mac_count=0 outside COMPUTE.
- psum_valid pulses per job: num_rows+N-1. MAC_shift pulses per job: TOTAL.
- Counter widths are sized to never wrap at num_rows=ROWS_MAX.

Decomposition:
- sys_arr_pkg holds:
  - MUL_LEN, ADD_LEN, derived STEP, DW.
  - typedef enum logic[1:0] ctrl_state_t {IDLE, LOAD_W, COMPUTE, DONE}.
- One natural sub-module: sysarr_step_timer. It owns mac_count and the end-cycle flag, and has a hold input. The FSM and the step/row counters stay in the top.

Test Plan:
- N=4, STEP=5, num_rows=3, all valid/ready=1. Required response:
  - 4 weight transfers (rows 0..3).
  - COMPUTE lasts 9 steps = 45 cycles.
  - MAC_shift pulses every 5th cycle (9 total).
  - psum_valid at s=3..8 with psum_step 0..5.
  - done 1 cycle after the last shift.
- reuse_weights=1, num_rows=1 -> no weight_ready, COMPUTE lasts 7 steps, 4 psum_valid pulses.
- input_valid low 3 cycles at step 1 end cycle -> mac_count holds at 4 for 3 extra cycles, MAC_shift=0 during the stall, total job length +3 cycles.
- out_ready low 2 cycles at step 3 -> psum_valid held 3 cycles with psum_step=0, exactly one advance.
- num_rows=0 -> done 1 cycle after start, busy for 1 cycle, no MAC_shift.
- nRST asserted at step 4 of COMPUTE -> all outputs 0 immediately, IDLE, no done pulse. A new start then runs a full job correctly.
